lenet5_frame_sched: RTL and testbench
=====================================

LENET5_FRAME_SCHED -- requirements
Module: lenet5_frame_sched

Interface
REQ-001 SHALL have parameter PIX_BITS, default 8, pixel width driven into the core.
REQ-002 SHALL have parameter IMG_PIX, default 1024, pixels per frame (32x32).
REQ-003 SHALL have parameter ADDR_W, default 20, pixel-memory word address width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 2000000, maximum wait cycles for a prediction after the last pixel.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a batch.
REQ-008 SHALL have port abort, input, 1, one-cycle request to cancel the batch.
REQ-009 SHALL have port num_frames, input, 16, frame count, sampled at an accepted start.
REQ-010 SHALL have port base_addr, input, ADDR_W, address of pixel 0 of frame 0, sampled at an accepted start.
REQ-011 SHALL have ports mem_rd_en (output, 1) and mem_addr (output, ADDR_W), the pixel-memory read request.
REQ-012 SHALL have port mem_rd_data, input, PIX_BITS, signed read data valid exactly 1 cycle after mem_rd_en.
REQ-013 SHALL have ports core_in_valid (output, 1), core_in_pix (output, PIX_BITS, signed) and core_in_ready (input, 1), the pixel stream into the core.
REQ-014 SHALL have ports core_pred_valid (input, 1) and core_pred_digit (input, 4), the core's argmax result.
REQ-015 SHALL have ports res_valid (output, 1), res_frame (output, 16) and res_digit (output, 4), the per-frame result.
REQ-016 SHALL have ports busy, done and timeout_err, each output, 1.

Function
REQ-017 SHALL implement states IDLE, STREAM, WAIT, REPORT and DONE.
REQ-018 In IDLE, start with num_frames>0 SHALL latch the config, clear timeout_err and enter STREAM.
REQ-019 In IDLE, start with num_frames==0 SHALL enter DONE and issue no memory reads.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 Addresses SHALL be base_addr + frame*IMG_PIX + pixel, produced by a running counter that wraps modulo 2^ADDR_W.
REQ-022 Fetched pixels SHALL pass through a 2-entry buffer.
REQ-023 A read SHALL issue when (entries + outstanding - pop_this_cycle) < 2 and fewer than IMG_PIX reads have been issued for the frame.
REQ-024 core_in_valid SHALL equal "buffer non-empty", and a pixel SHALL pop on core_in_valid & core_in_ready.
REQ-025 core_in_pix SHALL hold stable while core_in_valid & !core_in_ready.
REQ-026 Latency: with start at edge 0, mem_rd_en SHALL be high in cycle 1 and core_in_valid in cycle 3.
REQ-027 Throughput: with core_in_ready held high, the block SHALL deliver 1 pixel per cycle, i.e. IMG_PIX accepted pixels within IMG_PIX+2 cycles of first valid.
REQ-028 Acceptance of the IMG_PIX-th pixel SHALL move STREAM to WAIT and clear the wait counter.
REQ-029 In WAIT, core_pred_valid SHALL capture core_pred_digit and move to REPORT.
REQ-030 In WAIT, reaching TIMEOUT_CYC cycles SHALL set timeout_err (sticky until the next accepted start), force digit 4'hF and move to REPORT.
REQ-031 If core_pred_valid and timeout occur in the same cycle, the prediction SHALL win and timeout_err SHALL stay unchanged.
REQ-032 core_pred_valid outside WAIT SHALL be ignored.
REQ-033 REPORT SHALL pulse res_valid for 1 cycle with res_frame = frame index, then go to DONE if it was the last frame, else STREAM.
REQ-034 DONE SHALL pulse done for 1 cycle, then return to IDLE.
REQ-035 busy SHALL be high in STREAM, WAIT and REPORT.
REQ-036 abort in any non-IDLE state SHALL force IDLE next cycle: flush the buffer, discard the outstanding read return, no res_valid, no done; abort has priority over every other event.

Reset
REQ-037 rst_n low SHALL asynchronously force IDLE and drive mem_rd_en, core_in_valid, res_valid, busy, done, timeout_err low; mem_addr, core_in_pix, res_frame, res_digit 0; buffer empty, counters 0.
REQ-038 Reset mid-frame SHALL discard all in-flight data; the first action after release SHALL require a new start.

Structure
REQ-039 State encoding, IMG_PIX and the timeout digit code 4'hF SHALL live in the shared lenet5 package.
REQ-040 The 2-entry buffer SHALL be one sub-module, lenet5_pix_skid2, with push/pop/count ports.

Verification
REQ-041 Bench SHALL cover: start, num_frames=2, base_addr=0x100, ready always high, memory data=addr[7:0] -> addresses 0x100..0x8FF in order, 2048 pixels with no bubbles after first valid, res_frame 0 then 1, one done pulse.
REQ-042 Bench SHALL cover: ready toggled 1-in-3 -> in_pix stable across stalls, no pixel lost or duplicated (checksum match), at most 2 reads outstanding.
REQ-043 Bench SHALL cover: core never returns pred, TIMEOUT_CYC=100 -> res_valid 100 cycles after the last pixel with res_digit=4'hF and timeout_err=1, cleared by the next start.
REQ-044 Bench SHALL cover: pred_valid (digit 7) in the same cycle as timeout -> res_digit=7 and timeout_err=0.
REQ-045 Bench SHALL cover: abort at pixel 500 of frame 0 -> IDLE next cycle, no res_valid, no done; a new start restarts at base_addr.
REQ-046 Bench SHALL cover: num_frames=0, and base_addr=2^ADDR_W-10 -> done only with zero reads; address wraps to 0 after 10 pixels.

Source files
------------

// File: rtl/lenet5_pkg.sv
// lenet5_pkg: shared FSM encoding and constants for the LeNet-5 frame scheduler
package lenet5_pkg;
  typedef enum logic [2:0] {IDLE, STREAM, WAIT, REPORT, DONE} state_e;
  localparam int IMG_PIX_DEFAULT = 1024;
  localparam logic [3:0] TIMEOUT_DIGIT = 4'hF;
endpackage

// File: rtl/lenet5_pix_skid2.sv
// lenet5_pix_skid2: two-entry pixel buffer between memory read return and core input
module lenet5_pix_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [1:0] cnt_q, cnt_d, kept;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic popv;
  always_comb begin
    popv = pop && cnt_q != 2'd0;
    kept = cnt_q - {1'b0, popv};
    e0_d = (push && kept == 2'd0) ? push_data : popv ? e1_q : e0_q;
    e1_d = (push && kept != 2'd0) ? push_data : e1_q;
    cnt_d = flush ? 2'd0 : kept + {1'b0, push};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
  assign count = cnt_q;
  assign head = e0_q;
endmodule

// File: rtl/lenet5_frame_sched.sv
// lenet5_frame_sched: streams pixel frames from memory into the LeNet-5 core and reports one digit per frame
module lenet5_frame_sched import lenet5_pkg::*; #(
  parameter int PIX_BITS = 8,
  parameter int IMG_PIX = IMG_PIX_DEFAULT,
  parameter int ADDR_W = 20,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [15:0]                num_frames,
  input  logic [ADDR_W-1:0]          base_addr,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic signed [PIX_BITS-1:0] mem_rd_data,
  output logic                       core_in_valid,
  output logic signed [PIX_BITS-1:0] core_in_pix,
  input  logic                       core_in_ready,
  input  logic                       core_pred_valid,
  input  logic [3:0]                 core_pred_digit,
  output logic                       res_valid,
  output logic [15:0]                res_frame,
  output logic [3:0]                 res_digit,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err
);
  localparam int CW = $clog2(IMG_PIX + 1);
  localparam logic [CW-1:0] PIX_LAST = CW'(IMG_PIX - 1);
  localparam logic [CW-1:0] PIX_ALL = CW'(IMG_PIX);
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYC - 1);
  state_e state_q, state_d;
  logic [15:0] nframes_q, nframes_d, frame_q, frame_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0] issued_q, issued_d, acc_q, acc_d;
  logic [31:0] wait_q, wait_d;
  logic [3:0] digit_q, digit_d;
  logic tmo_q, tmo_d, out_q, out_d;
  logic [1:0] cnt;
  logic [2:0] occ;
  logic pop, rd, flush;
  lenet5_pix_skid2 #(.W(PIX_BITS)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .push(out_q),
    .push_data(mem_rd_data),
    .pop(pop),
    .count(cnt),
    .head(core_in_pix)
  );
  // occupancy counts buffered pixels plus the read in flight, net of this cycle's pop
  always_comb begin
    pop = cnt != 2'd0 && core_in_ready;
    occ = 3'(cnt) + 3'(out_q) - 3'(pop);
    flush = abort && state_q != IDLE;
    rd = state_q == STREAM && !abort && occ < 3'd2 && issued_q != PIX_ALL;
    state_d = state_q;
    nframes_d = nframes_q;
    frame_d = frame_q;
    addr_d = addr_q + ADDR_W'(rd);
    issued_d = issued_q + CW'(rd);
    acc_d = acc_q + CW'(pop);
    wait_d = wait_q;
    digit_d = digit_q;
    tmo_d = tmo_q;
    out_d = rd;
    if (flush) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        if (num_frames == 16'd0) state_d = DONE;
        else begin
          state_d = STREAM;
          nframes_d = num_frames;
          frame_d = 16'd0;
          addr_d = base_addr;
          issued_d = '0;
          acc_d = '0;
          tmo_d = 1'b0;
        end
      end
      STREAM: if (pop && acc_q == PIX_LAST) begin
        state_d = WAIT;
        wait_d = 32'd0;
      end
      WAIT: begin
        wait_d = wait_q + 32'd1;
        if (core_pred_valid) begin
          digit_d = core_pred_digit;
          state_d = REPORT;
        end else if (wait_q == WAIT_LAST) begin
          digit_d = TIMEOUT_DIGIT;
          tmo_d = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: if (frame_q == nframes_q - 16'd1) state_d = DONE;
      else begin
        frame_d = frame_q + 16'd1;
        issued_d = '0;
        acc_d = '0;
        state_d = STREAM;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      nframes_q <= 16'd0;
      frame_q <= 16'd0;
      addr_q <= '0;
      issued_q <= '0;
      acc_q <= '0;
      wait_q <= 32'd0;
      digit_q <= 4'd0;
      tmo_q <= 1'b0;
      out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nframes_q <= nframes_d;
      frame_q <= frame_d;
      addr_q <= addr_d;
      issued_q <= issued_d;
      acc_q <= acc_d;
      wait_q <= wait_d;
      digit_q <= digit_d;
      tmo_q <= tmo_d;
      out_q <= out_d;
    end
  end
  assign mem_rd_en = rd;
  assign mem_addr = addr_q;
  assign core_in_valid = cnt != 2'd0;
  assign res_valid = state_q == REPORT && !abort;
  assign res_frame = frame_q;
  assign res_digit = digit_q;
  assign busy = state_q == STREAM || state_q == WAIT || state_q == REPORT;
  assign done = state_q == DONE && !abort;
  assign timeout_err = tmo_q;
endmodule

// File: tb/tb_lenet5_frame_sched.sv
// tb_lenet5_frame_sched: directed scenarios with a stream-level model checking addresses, pixels and results
module tb_lenet5_frame_sched;
  localparam int IMG = 1024;
  localparam int TMO = 100;
  logic clk = 1'b0, rst_n, start, abort, mem_rd_en, core_in_valid, core_in_ready;
  logic core_pred_valid, res_valid, busy, done, timeout_err;
  logic [15:0] num_frames, res_frame;
  logic [19:0] base_addr, mem_addr;
  logic [7:0] mem_rd_data = 8'd0, core_in_pix;
  logic [3:0] core_pred_digit, res_digit;
  always #5 clk = ~clk;

  lenet5_frame_sched #(.PIX_BITS(8), .IMG_PIX(IMG), .ADDR_W(20), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_frames(num_frames),
    .base_addr(base_addr), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .core_in_valid(core_in_valid), .core_in_pix(core_in_pix), .core_in_ready(core_in_ready),
    .core_pred_valid(core_pred_valid), .core_pred_digit(core_pred_digit), .res_valid(res_valid),
    .res_frame(res_frame), .res_digit(res_digit), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  // pixel memory: each word holds the low byte of its own address
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr[7:0];

  int vecs = 0, errs = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // test-side controls
  int gen = 0, mode = 0, pd_base = 3, pd_delay = 5;
  logic [19:0] exp_base = 20'd0;

  // core model: ready pattern, and a prediction pd_delay cycles after each frame's last pixel
  initial begin
    int facc, fidx, cd, g, k;
    logic [3:0] dig;
    facc = 0; fidx = 0; cd = -1; g = 0; k = 0; dig = 4'd0;
    core_in_ready = 1'b1; core_pred_valid = 1'b0; core_pred_digit = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst_n || gen != g) begin g = gen; facc = 0; fidx = 0; cd = -1; end
      if (rst_n && core_in_valid && core_in_ready) begin
        facc++;
        if (facc == IMG) begin
          facc = 0;
          dig = 4'(pd_base + 5 * fidx);
          fidx++;
          cd = pd_delay > 0 ? pd_delay : -1;
        end
      end
      @(posedge clk); #1;
      k++;
      core_in_ready = mode == 0 || k % 3 == 0;
      if (cd > 0) cd--;
      core_pred_valid = cd == 0;
      core_pred_digit = cd == 0 ? dig : 4'd0;
      if (cd == 0) cd = -1;
    end
  end

  // stream model: batch k reads address base+k and delivers pixel (base+k)[7:0], in order
  typedef struct {int frame; int digit; int tmo; int lat;} res_t;
  res_t res_q[$];
  int cyc = 0, seen_gen = 0, m_rd = 0, m_acc = 0, sum = 0, res_n = 0, done_n = 0;
  int c_start = 0, fv = -1, last_acc = 0;
  bit have_rd = 0, have_v = 0, prev_stall = 0;
  logic [7:0] prev_pix = 8'd0;
  logic [19:0] last_rd = 20'd0, rd10 = 20'hFFFFF;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin prev_stall = 0; continue; end
    if (gen != seen_gen) begin
      seen_gen = gen; m_rd = 0; m_acc = 0; sum = 0; res_n = 0; c_start = cyc;
      have_rd = 0; have_v = 0; fv = -1; res_q.delete();
    end
    if (prev_stall) begin
      chk("stall_valid", core_in_valid, 1);
      chk("stall_pix", core_in_pix, prev_pix);
    end
    chk("outstanding_le2", (m_rd - m_acc) <= 2, 1);
    if (mem_rd_en) begin
      if (!have_rd) begin chk("rd_latency", cyc - c_start, 1); have_rd = 1; end
      chk("rd_addr", mem_addr, 20'(exp_base + 20'(m_rd)));
      if (m_rd == 10) rd10 = mem_addr;
      last_rd = mem_addr;
      m_rd++;
    end
    if (core_in_valid) begin
      if (!have_v) begin chk("valid_latency", cyc - c_start, 3); have_v = 1; end
      if (fv < 0) fv = cyc;
    end
    if (core_in_valid && core_in_ready) begin
      chk("pix", core_in_pix, 8'(exp_base + 20'(m_acc)));
      sum += int'(core_in_pix);
      m_acc++;
      last_acc = cyc;
      if (m_acc % IMG == 0) begin
        if (mode == 0) chk("frame_span", (cyc - fv + 1) <= IMG + 2, 1);
        fv = -1;
      end
    end
    if (res_valid) begin
      chk("res_frame", res_frame, res_n);
      res_q.push_back('{int'(res_frame), int'(res_digit), int'(timeout_err), cyc - last_acc});
      res_n++;
    end
    if (done) done_n++;
    prev_stall = core_in_valid && !core_in_ready && !abort;
    prev_pix = core_in_pix;
  end

  task automatic go(input logic [15:0] n, input logic [19:0] b);
    @(posedge clk); #1;
    exp_base = b; gen++; num_frames = n; base_addr = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int d0, k;
    d0 = done_n; k = 0;
    while (done_n == d0 && k < lim) begin @(negedge clk); k++; end
    chk("done_seen", done_n != d0, 1);
  endtask

  task automatic chk_res(input string nm, input int idx, input int fr, input int dg, input int tm);
    chk({nm, "_count"}, res_q.size() > idx, 1);
    if (res_q.size() > idx) begin
      chk({nm, "_frame"}, res_q[idx].frame, fr);
      chk({nm, "_digit"}, res_q[idx].digit, dg);
      chk({nm, "_tmo"}, res_q[idx].tmo, tm);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, k;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_frames = 16'd0; base_addr = 20'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", core_in_valid, 0);
    chk("rst_pix", core_in_pix, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_frame", res_frame, 0);
    chk("rst_res_digit", res_digit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tmo", timeout_err, 0);
    rst_n = 1'b1;

    // two frames at 0x100, ready high: bytes of 0x100..0x8FF sum to 8*32640
    go(2, 20'h100);
    wait_done(5000);
    chk("t1_reads", m_rd, 2048);
    chk("t1_pixels", m_acc, 2048);
    chk("t1_last_addr", last_rd, 20'h8FF);
    chk("t1_sum", sum, 261120);
    chk_res("t1_r0", 0, 0, 3, 0);
    chk_res("t1_r1", 1, 1, 8, 0);
    chk("t1_done_count", done_n, 1);

    // ready 1-in-3: 1024 consecutive bytes from 0x37 sum to 4*32640
    mode = 1;
    go(1, 20'h37);
    wait_done(6000);
    chk("t2_pixels", m_acc, 1024);
    chk("t2_sum", sum, 130560);
    chk_res("t2_r0", 0, 0, 3, 0);
    mode = 0;

    // no prediction: 100 WAIT cycles separate the last pixel from res_valid
    pd_delay = 0;
    go(1, 20'h0);
    wait_done(3000);
    chk_res("t3_r0", 0, 0, 15, 1);
    if (res_q.size() > 0) chk("t3_lat", res_q[0].lat, TMO + 1);
    chk("t3_tmo_sticky", timeout_err, 1);

    // prediction lands on the timeout cycle and wins
    pd_delay = TMO; pd_base = 7;
    go(1, 20'h200);
    chk("t4_tmo_cleared", timeout_err, 0);
    wait_done(3000);
    chk_res("t4_r0", 0, 0, 7, 0);
    if (res_q.size() > 0) chk("t4_lat", res_q[0].lat, TMO + 1);
    chk("t4_tmo_final", timeout_err, 0);

    // abort mid frame 0, then restart from the same base
    pd_delay = 5; pd_base = 3;
    d0 = done_n;
    go(2, 20'h40);
    k = 0;
    while (m_acc < 500 && k < 2000) begin @(negedge clk); k++; end
    chk("t5_reached_500", m_acc >= 500, 1);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_valid", core_in_valid, 0);
    chk("t5_rd_en", mem_rd_en, 0);
    repeat (20) @(negedge clk);
    chk("t5_no_res", res_n, 0);
    chk("t5_no_done", done_n, d0);
    go(1, 20'h40);
    wait_done(3000);
    chk("t5_sum", sum, 130560);
    chk_res("t5_r0", 0, 0, 3, 0);

    // zero frames: done only, no reads
    d0 = done_n;
    go(0, 20'h123);
    repeat (5) @(negedge clk);
    chk("t6_done", done_n, d0 + 1);
    chk("t6_reads", m_rd, 0);
    chk("t6_busy", busy, 0);

    // address wrap at the top of memory
    go(1, 20'hFFFF6);
    wait_done(3000);
    chk("t7_wrap", rd10, 20'h0);
    chk("t7_reads", m_rd, 1024);

    // asynchronous reset mid-frame, then nothing until a new start
    go(1, 20'h0);
    k = 0;
    while (m_acc < 50 && k < 500) begin @(negedge clk); k++; end
    #2 rst_n = 1'b0;
    #1;
    chk("t8_busy", busy, 0);
    chk("t8_rd_en", mem_rd_en, 0);
    chk("t8_valid", core_in_valid, 0);
    @(posedge clk); #1;
    gen++;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t8_no_reads", m_rd, 0);
    chk("t8_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
